// File: rtl/binary_down_counter_if.sv
// Handshake/data bundle for binary_down_counter.
// The master drives load/start/pause and the slave returns count/busy/done.
interface binary_down_counter_if #(
  parameter int WIDTH = 6
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_value, start, pause,
    input  count, busy, done
  );

  modport slave (
    input  load, load_value, start, pause,
    output count, busy, done
  );
endinterface

// File: rtl/binary_down_counter.sv
// Loadable down-counter/timer with a start/pause handshake and a one-cycle done pulse.
// Optional periodic reload at terminal count: define DOWN_COUNTER_AUTORELOAD_EN.
module binary_down_counter #(
  parameter int WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  binary_down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state, next-count and registered-output computation
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      count_d = bus.load_value;
      state_d = LOADED;
      busy_d  = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_d = bus.load_value;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
        end
        LOADED: begin
          if (bus.start) begin
            if (count_q != ZERO) begin
              state_d = RUN;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            busy_d = 1'b0;
          end
        end
        RUN, HOLD: begin
          // Releasing pause from HOLD decrements on that same edge, so a
          // pause lasting P cycles delays completion by exactly P cycles.
          if (bus.pause) begin
            state_d = HOLD;
            busy_d  = 1'b1;
          end else if (count_q == ONE) begin
            count_d = ZERO;
            done_d  = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            if (bus.start && (reload_q != ZERO)) begin
              state_d = RUN;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
`else
            state_d = IDLE;
            busy_d  = 1'b0;
`endif
          end else if (count_q == ZERO) begin
            // Only reachable after an auto-reload terminal: restart the period.
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            if (reload_q != ZERO) begin
              count_d = reload_q;
              state_d = RUN;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
`else
            state_d = IDLE;
            busy_d  = 1'b0;
`endif
          end else begin
            count_d = count_q - ONE;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
